// File: rtl/approx_add_pkg.sv
// rtl/approx_add_pkg.sv - default sizing and mode encoding for the shared approximate adder
package approx_add_pkg;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_APPROX_BITS = 9;
    localparam int DEF_NREQ        = 4;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } add_mode_e;

endpackage

// File: rtl/approx_rc_adder.sv
// rtl/approx_rc_adder.sv - ripple-carry adder whose low slices can switch to an approximate cell
module approx_rc_adder
    import approx_add_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_BITS = DEF_APPROX_BITS
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] carry;

    // Approximate cell: sum = ~cin, cout = 0, so the exact upper part starts with no carry.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (mode == MODE_APPROX && k < APPROX_BITS) begin
                sum[k]     = ~carry[k];
                carry[k+1] = 1'b0;
            end else begin
                sum[k]     = a[k] ^ b[k] ^ carry[k];
                carry[k+1] = (a[k] & b[k]) | (carry[k] & (a[k] ^ b[k]));
            end
        end
        sum[WIDTH] = carry[WIDTH];
    end

endmodule

// File: rtl/approx_add_arbiter.sv
// rtl/approx_add_arbiter.sv - round-robin sharing of one approximate adder with a registered result
module approx_add_arbiter
    import approx_add_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_BITS = DEF_APPROX_BITS,
    parameter int NREQ        = DEF_NREQ,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_in1,
    input  logic [NREQ*WIDTH-1:0]     req_in2,
    input  logic [NREQ-1:0]           req_approx,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [WIDTH:0]            res_sum,
    output logic [$clog2(NREQ)-1:0]   res_id,
    output logic                      res_approx,
    output logic [CNT_W-1:0]          approx_cnt,
    input  logic                      cnt_clr
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    logic             slot_free;
    logic             xfer;
    int               rr_idx;
    logic [WIDTH-1:0] sel_in1;
    logic [WIDTH-1:0] sel_in2;
    logic             sel_mode;
    logic [WIDTH:0]   add_sum;

    assign slot_free = !res_valid || res_ready;
    assign xfer      = slot_free && gnt_found;

    // First valid requester at or above ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rr_idx    = 0;
        for (int j = 0; j < NREQ; j++) begin
            rr_idx = (int'(ptr) + j) % NREQ;
            if (!gnt_found && req_valid[IDW'(rr_idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(rr_idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_in1  = '0;
        sel_in2  = '0;
        sel_mode = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_in1  = req_in1[i*WIDTH +: WIDTH];
                sel_in2  = req_in2[i*WIDTH +: WIDTH];
                sel_mode = req_approx[i];
            end
        end
    end

    approx_rc_adder #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_adder (
        .a    (sel_in1),
        .b    (sel_in2),
        .mode (sel_mode),
        .sum  (add_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_sum    <= '0;
            res_id     <= '0;
            res_approx <= 1'b0;
            ptr        <= '0;
        end else if (xfer) begin
            res_valid  <= 1'b1;
            res_sum    <= add_sum;
            res_id     <= gnt_idx;
            res_approx <= sel_mode;
            ptr        <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (res_ready) begin
            res_valid  <= 1'b0;
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            approx_cnt <= '0;
        end else if (cnt_clr) begin
            approx_cnt <= '0;
        end else if (xfer && sel_mode == MODE_APPROX && approx_cnt != '1) begin
            approx_cnt <= approx_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_approx_add_arbiter.sv
// tb/tb_approx_add_arbiter.sv - self-checking bench for approx_add_arbiter
module tb_approx_add_arbiter;

    localparam int W  = 16;
    localparam int A  = 9;
    localparam int N  = 4;
    localparam int CW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_in1;
    logic [N*W-1:0] req_in2;
    logic [N-1:0]   req_approx;
    logic           res_valid;
    logic           res_ready;
    logic [W:0]     res_sum;
    logic [1:0]     res_id;
    logic           res_approx;
    logic [CW-1:0]  approx_cnt;
    logic           cnt_clr;

    logic [W-1:0]   op1 [N];
    logic [W-1:0]   op2 [N];

    int checks   = 0;
    int failures = 0;

    bit             m_valid;
    int             m_sum;
    int             m_id;
    int             m_ptr;
    int             m_cnt;
    bit             m_approx;
    logic [N-1:0]   obs_ready;
    int             last_g;

    typedef struct {
        int         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit         ap;
        logic [W:0] exp_sum;
    } vec_t;

    vec_t tbl [6];

    approx_add_arbiter #(
        .WIDTH       (W),
        .APPROX_BITS (A),
        .NREQ        (N),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_approx (req_approx),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_id     (res_id),
        .res_approx (res_approx),
        .approx_cnt (approx_cnt),
        .cnt_clr    (cnt_clr)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_in1[i*W +: W] = op1[i];
            req_in2[i*W +: W] = op2[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ref_sum(input int a, input int b, input bit ap);
        if (ap) return (((a >> A) + (b >> A)) << A) + ((1 << A) - 1);
        return a + b;
    endfunction

    task automatic model_reset();
        m_valid  = 0;
        m_sum    = 0;
        m_id     = 0;
        m_ptr    = 0;
        m_cnt    = 0;
        m_approx = 0;
    endtask

    // Called just after an edge with inputs already driven; checks grant, then the next edge's outputs.
    task automatic cycle(input string tag);
        int g;
        int idx;
        bit sf;
        logic [N-1:0] er;
        #3;
        sf = !m_valid || res_ready;
        g  = -1;
        if (sf) begin
            for (int j = 0; j < N; j++) begin
                idx = (m_ptr + j) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        obs_ready = req_ready;
        last_g    = g;
        chk({tag, " req_ready"}, 32'(req_ready), 32'(er));
        if (cnt_clr) m_cnt = 0;
        else if (g >= 0 && req_approx[g] && m_cnt < (1 << CW) - 1) m_cnt++;
        if (g >= 0) begin
            m_sum    = ref_sum(int'(op1[g]), int'(op2[g]), req_approx[g]);
            m_id     = g;
            m_approx = req_approx[g];
            m_valid  = 1;
            m_ptr    = (g + 1) % N;
        end else if (res_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk({tag, " res_valid"},  32'(res_valid),  32'(m_valid));
        chk({tag, " res_sum"},    32'(res_sum),    m_sum);
        chk({tag, " res_id"},     32'(res_id),     m_id);
        chk({tag, " res_approx"}, 32'(res_approx), 32'(m_approx));
        chk({tag, " approx_cnt"}, 32'(approx_cnt), m_cnt);
    endtask

    initial begin
        logic [W:0] saved_sum;

        tbl[0] = '{1, 16'h1234, 16'h0F0F, 1'b0, 17'h02143};
        tbl[1] = '{1, 16'h1234, 16'h0F0F, 1'b1, 17'h021FF};
        tbl[2] = '{2, 16'hFFFF, 16'h0001, 1'b1, 17'h0FFFF};
        tbl[3] = '{0, 16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE};
        tbl[4] = '{3, 16'h0000, 16'h0000, 1'b1, 17'h001FF};
        tbl[5] = '{3, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FDFF};

        rst        = 1'b1;
        req_valid  = '0;
        req_approx = '0;
        res_ready  = 1'b0;
        cnt_clr    = 1'b0;
        for (int i = 0; i < N; i++) begin
            op1[i] = '0;
            op2[i] = '0;
        end
        model_reset();
        last_g = -1;

        @(posedge clk);
        #2;
        chk("reset res_valid",  32'(res_valid),  0);
        chk("reset res_sum",    32'(res_sum),    0);
        chk("reset res_id",     32'(res_id),     0);
        chk("reset res_approx", 32'(res_approx), 0);
        chk("reset approx_cnt", 32'(approx_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single-requester vectors
        res_ready = 1'b1;
        foreach (tbl[v]) begin
            req_valid = '0;
            req_valid[tbl[v].id]  = 1'b1;
            req_approx[tbl[v].id] = tbl[v].ap;
            op1[tbl[v].id]        = tbl[v].a;
            op2[tbl[v].id]        = tbl[v].b;
            cycle("vec");
            chk("vec grant",      32'(obs_ready),  32'(1 << tbl[v].id));
            chk("vec sum",        32'(res_sum),    32'(tbl[v].exp_sum));
            chk("vec id",         32'(res_id),     tbl[v].id);
            chk("vec approx",     32'(res_approx), 32'(tbl[v].ap));
            req_valid = '0;
        end
        chk("vec approx_cnt", 32'(approx_cnt), 4);

        // Backpressure: hold a result for 5 cycles while everyone waits
        cycle("drain");
        req_valid    = 4'b0100;
        req_approx   = 4'b0000;
        op1[2]       = 16'h1111;
        op2[2]       = 16'h2222;
        res_ready    = 1'b0;
        cycle("bp load");
        saved_sum = res_sum;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            op1[i] = 16'(i * 16'h0101);
            op2[i] = 16'h0F00;
        end
        repeat (5) begin
            cycle("bp stall");
            chk("bp ready",  32'(obs_ready), 0);
            chk("bp hold",   32'(res_sum),   32'(saved_sum));
            chk("bp id",     32'(res_id),    2);
            chk("bp valid",  32'(res_valid), 1);
        end
        res_ready = 1'b1;
        cycle("bp release");
        chk("bp release grant", 32'(obs_ready), 32'(4'b1000));
        chk("bp release id",    32'(res_id),    3);
        req_valid = '0;
        cycle("drain");

        // Counter saturation and clear priority
        cnt_clr = 1'b1;
        cycle("clr");
        cnt_clr    = 1'b0;
        req_valid  = 4'b0001;
        req_approx = 4'b0001;
        op1[0]     = 16'hABCD;
        op2[0]     = 16'h1357;
        repeat ((1 << CW) - 2) cycle("sat fill");
        chk("sat pre", 32'(approx_cnt), (1 << CW) - 2);
        repeat (3) cycle("sat");
        chk("sat top", 32'(approx_cnt), (1 << CW) - 1);
        cnt_clr = 1'b1;
        cycle("clr+inc");
        chk("clr+inc grant", 32'(obs_ready),  32'(4'b0001));
        chk("clr+inc cnt",   32'(approx_cnt), 0);
        cnt_clr   = 1'b0;
        req_valid = '0;
        cycle("drain");

        // Reset while a result is stalled
        req_valid  = 4'b0100;
        req_approx = 4'b0100;
        res_ready  = 1'b0;
        cycle("rst load");
        req_valid = '0;
        cycle("rst stall");
        chk("rst pre valid", 32'(res_valid), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("rst async valid", 32'(res_valid),  0);
        chk("rst async cnt",   32'(approx_cnt), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin with all requesters continuously valid
        req_valid  = 4'b1111;
        req_approx = 4'b0000;
        res_ready  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle("rr");
            if (k == 0) chk("rr first grant", 32'(obs_ready), 32'(4'b0001));
            chk("rr id",    32'(res_id),    k % N);
            chk("rr valid", 32'(res_valid), 1);
        end

        // Random traffic; a requester keeps valid and operands until it is granted
        last_g = -1;
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_g == i) begin
                    req_valid[i]  = ($urandom_range(0, 2) != 0);
                    req_approx[i] = 1'($urandom_range(0, 1));
                    op1[i]        = 16'($urandom);
                    op2[i]        = 16'($urandom);
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 29) == 0);
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
